demosaic_mhc_pipe: RTL and testbench

Pipelined, parameterised Malvar-He-Cutler demosaic core. Each cycle it takes one 5x5 Bayer window and the parity of the window centre, and produces a full R/G/B triple for that centre. All four site kernels (G at R/B, R/B at G in either row orientation, R at B, B at R) are evaluated in parallel at full precision, then one rounding and one saturation step is applied. It sits between the line-buffer/window generator and the RGB output formatter, with valid/ready flow control on both sides.

---
 rtl/demosaic_pkg.sv | 30 +++
 rtl/demosaic_round_sat.sv | 35 +++
 rtl/demosaic_mhc_pipe.sv | 159 +++++++++++++++
 tb/tb_demosaic_mhc_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demosaic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demosaic_pkg
// Purpose  : Shared types and constants for the Malvar-He-Cutler demosaic core.
// Revision : 1.0 - initial release
// ============================================================================
package demosaic_pkg;

  typedef enum logic [1:0] {
    SITE_R  = 2'd0,
    SITE_GR = 2'd1,
    SITE_GB = 2'd2,
    SITE_B  = 2'd3
  } site_e;

  localparam int c_BAYER_RGGB = 0;
  localparam int c_BAYER_GRBG = 1;
  localparam int c_BAYER_GBRG = 2;
  localparam int c_BAYER_BGGR = 3;

  // Kernels are evaluated at x16 scale.
  localparam int c_KERN_SHIFT = 4;
  localparam int c_KERN_RND   = 8;

  function automatic int ACC_W(input int data_w);
    return data_w + 7;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demosaic_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : demosaic_round_sat
// Purpose  : Round-half-up a x16 signed kernel sum and clamp it to pixel range.
// Revision : 1.0 - initial release
// ============================================================================
module demosaic_round_sat
  import demosaic_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic signed [ACC_W(DATA_W)-1:0] i_acc,
  output logic        [DATA_W-1:0]        o_pix
);

  localparam int c_AW = ACC_W(DATA_W);
  localparam logic signed [c_AW-1:0] c_RND = c_AW'(c_KERN_RND);

  logic signed [c_AW-1:0] w_sum;
  logic signed [c_AW-1:0] w_shr;

  assign w_sum = i_acc + c_RND;
  assign w_shr = w_sum >>> c_KERN_SHIFT;

  always_comb begin
    o_pix = w_shr[DATA_W-1:0];
    if (w_shr[c_AW-1]) begin
      o_pix = '0;
    end else if (|w_shr[c_AW-2:DATA_W]) begin
      o_pix = '1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/demosaic_mhc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : demosaic_mhc_pipe
// Purpose  : Three-stage MHC demosaic: group sums, four kernels, round/select.
// Revision : 1.0 - initial release
// ============================================================================
module demosaic_mhc_pipe
  import demosaic_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int BAYER  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [25*DATA_W-1:0]  in_win,
  input  logic                  in_row_odd,
  input  logic                  in_col_odd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_r,
  output logic [DATA_W-1:0]     out_g,
  output logic [DATA_W-1:0]     out_b
);

  localparam int c_AW = ACC_W(DATA_W);
  localparam int c_SW = DATA_W + 2;
  localparam logic [1:0] c_PHASE = (BAYER == c_BAYER_GRBG) ? 2'b01 :
                                   (BAYER == c_BAYER_GBRG) ? 2'b10 :
                                   (BAYER == c_BAYER_BGGR) ? 2'b11 : 2'b00;

  logic [DATA_W-1:0] w_d [1:5][1:5];

  for (genvar i = 1; i <= 5; i++) begin : g_row
    for (genvar j = 1; j <= 5; j++) begin : g_col
      assign w_d[i][j] = in_win[((i-1)*5+(j-1))*DATA_W +: DATA_W];
    end
  end

  // The outer ring corners and off-axis edge pixels carry no MHC weight.
  logic w_unused_px;
  assign w_unused_px = ^{w_d[1][1], w_d[1][2], w_d[1][4], w_d[1][5],
                         w_d[2][1], w_d[2][5], w_d[4][1], w_d[4][5],
                         w_d[5][1], w_d[5][2], w_d[5][4], w_d[5][5]};

  function automatic logic [c_SW-1:0] zx(input logic [DATA_W-1:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic signed [c_AW-1:0] sx(input logic [c_SW-1:0] v);
    return $signed({{(c_AW-c_SW){1'b0}}, v});
  endfunction

  logic              w_en;
  site_e             w_site;
  logic              r1_v, r2_v, r3_v;
  site_e             r1_site, r2_site;
  logic [DATA_W-1:0] r1_c, r2_c;
  logic [c_SW-1:0]   r1_ns1, r1_we1, r1_ns2, r1_we2, r1_x;
  logic signed [c_AW-1:0] r2_kg, r2_kh, r2_kv, r2_kd;
  logic [DATA_W-1:0] r3_r, r3_g, r3_b;

  assign w_en      = !r3_v || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r3_v;
  assign out_r     = r3_r;
  assign out_g     = r3_g;
  assign out_b     = r3_b;

  assign w_site = site_e'({in_row_odd ^ c_PHASE[1], in_col_odd ^ c_PHASE[0]});

  logic signed [c_AW-1:0] w_c, w_ns1, w_we1, w_ns2, w_we2, w_x;
  logic signed [c_AW-1:0] w_kg, w_kh, w_kv, w_kd;

  assign w_c   = $signed({{(c_AW-DATA_W){1'b0}}, r1_c});
  assign w_ns1 = sx(r1_ns1);
  assign w_we1 = sx(r1_we1);
  assign w_ns2 = sx(r1_ns2);
  assign w_we2 = sx(r1_we2);
  assign w_x   = sx(r1_x);

  assign w_kg = (w_c <<< 3) + ((w_ns1 + w_we1) <<< 2) - ((w_ns2 + w_we2) <<< 1);
  assign w_kh = (w_c <<< 3) + (w_c <<< 1) + (w_we1 <<< 3) - (w_we2 <<< 1)
              - (w_x <<< 1) + w_ns2;
  assign w_kv = (w_c <<< 3) + (w_c <<< 1) + (w_ns1 <<< 3) - (w_ns2 <<< 1)
              - (w_x <<< 1) + w_we2;
  assign w_kd = (w_c <<< 3) + (w_c <<< 2) + (w_x <<< 2)
              - ((w_ns2 + w_we2) <<< 1) - (w_ns2 + w_we2);

  logic [DATA_W-1:0] w_pg, w_ph, w_pv, w_pd;

  demosaic_round_sat #(.DATA_W(DATA_W)) u_rs_kg (.i_acc(r2_kg), .o_pix(w_pg));
  demosaic_round_sat #(.DATA_W(DATA_W)) u_rs_kh (.i_acc(r2_kh), .o_pix(w_ph));
  demosaic_round_sat #(.DATA_W(DATA_W)) u_rs_kv (.i_acc(r2_kv), .o_pix(w_pv));
  demosaic_round_sat #(.DATA_W(DATA_W)) u_rs_kd (.i_acc(r2_kd), .o_pix(w_pd));

  logic [DATA_W-1:0] w_sel_r, w_sel_g, w_sel_b;

  always_comb begin
    w_sel_r = r2_c;
    w_sel_g = r2_c;
    w_sel_b = r2_c;
    case (r2_site)
      SITE_R:  begin w_sel_g = w_pg; w_sel_b = w_pd; end
      SITE_GR: begin w_sel_r = w_ph; w_sel_b = w_pv; end
      SITE_GB: begin w_sel_r = w_pv; w_sel_b = w_ph; end
      SITE_B:  begin w_sel_r = w_pd; w_sel_g = w_pg; end
      default: ;
    endcase
  end

  // All stages share one enable, so a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v    <= 1'b0;
      r2_v    <= 1'b0;
      r3_v    <= 1'b0;
      r1_site <= SITE_R;
      r2_site <= SITE_R;
      r1_c    <= '0;
      r2_c    <= '0;
      r1_ns1  <= '0;
      r1_we1  <= '0;
      r1_ns2  <= '0;
      r1_we2  <= '0;
      r1_x    <= '0;
      r2_kg   <= '0;
      r2_kh   <= '0;
      r2_kv   <= '0;
      r2_kd   <= '0;
      r3_r    <= '0;
      r3_g    <= '0;
      r3_b    <= '0;
    end else if (w_en) begin
      r1_v    <= in_valid;
      r1_site <= w_site;
      r1_c    <= w_d[3][3];
      r1_ns1  <= zx(w_d[2][3]) + zx(w_d[4][3]);
      r1_we1  <= zx(w_d[3][2]) + zx(w_d[3][4]);
      r1_ns2  <= zx(w_d[1][3]) + zx(w_d[5][3]);
      r1_we2  <= zx(w_d[3][1]) + zx(w_d[3][5]);
      r1_x    <= zx(w_d[2][2]) + zx(w_d[2][4]) + zx(w_d[4][2]) + zx(w_d[4][4]);
      r2_v    <= r1_v;
      r2_site <= r1_site;
      r2_c    <= r1_c;
      r2_kg   <= w_kg;
      r2_kh   <= w_kh;
      r2_kv   <= w_kv;
      r2_kd   <= w_kd;
      r3_v    <= r2_v;
      r3_r    <= w_sel_r;
      r3_g    <= w_sel_g;
      r3_b    <= w_sel_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demosaic_mhc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_demosaic_mhc_pipe
// Purpose  : Directed and randomized checks of the MHC demosaic pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demosaic_mhc_pipe;

  localparam int DW    = 10;
  localparam int BAYER = 3;
  localparam int MAXV  = (1 << DW) - 1;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
  } rgb_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [25*DW-1:0] in_win;
  logic            in_row_odd;
  logic            in_col_odd;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_r, out_g, out_b;

  int   checks = 0;
  int   errors = 0;
  int   sent   = 0;
  int   rcv    = 0;
  rgb_t q[$];
  bit   have_prev = 0;
  rgb_t prev;

  demosaic_mhc_pipe #(.DATA_W(DW), .BAYER(BAYER)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
    .in_row_odd(in_row_odd), .in_col_odd(in_col_odd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int fin(input int k);
    int v;
    v = k + 8;
    if (v < 0) return 0;
    v = v / 16;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  // Reference model: plain integer arithmetic straight from the kernel formulas.
  function automatic rgb_t model(input logic [25*DW-1:0] w, input logic ro, input logic co);
    int d [1:5][1:5];
    int c, x, kg, kh, kv, kd;
    bit rr, cc;
    rgb_t o;
    for (int i = 1; i <= 5; i++)
      for (int j = 1; j <= 5; j++)
        d[i][j] = int'(w[((i-1)*5+(j-1))*DW +: DW]);
    c  = d[3][3];
    x  = d[2][2] + d[2][4] + d[4][2] + d[4][4];
    kg = 8*c + 4*(d[2][3]+d[4][3]+d[3][2]+d[3][4]) - 2*(d[1][3]+d[5][3]+d[3][1]+d[3][5]);
    kh = 10*c + 8*(d[3][2]+d[3][4]) - 2*(d[3][1]+d[3][5]) - 2*x + (d[1][3]+d[5][3]);
    kv = 10*c + 8*(d[2][3]+d[4][3]) - 2*(d[1][3]+d[5][3]) - 2*x + (d[3][1]+d[3][5]);
    kd = 12*c + 4*x - 3*(d[1][3]+d[5][3]+d[3][1]+d[3][5]);
    rr = ro ^ (((BAYER >> 1) & 1) != 0);
    cc = co ^ ((BAYER & 1) != 0);
    if (!rr && !cc)     begin o.r = DW'(c);        o.g = DW'(fin(kg)); o.b = DW'(fin(kd)); end
    else if (!rr && cc) begin o.r = DW'(fin(kh));  o.g = DW'(c);       o.b = DW'(fin(kv)); end
    else if (rr && !cc) begin o.r = DW'(fin(kv));  o.g = DW'(c);       o.b = DW'(fin(kh)); end
    else                begin o.r = DW'(fin(kd));  o.g = DW'(fin(kg)); o.b = DW'(c);       end
    return o;
  endfunction

  function automatic logic [25*DW-1:0] put(input logic [25*DW-1:0] w, input int i,
                                            input int j, input int v);
    logic [25*DW-1:0] t;
    t = w;
    t[((i-1)*5+(j-1))*DW +: DW] = DW'(v);
    return t;
  endfunction

  function automatic logic [25*DW-1:0] rand_win();
    logic [25*DW-1:0] t;
    t = '0;
    for (int k = 0; k < 25; k++) begin
      case ($urandom % 4)
        0:       t[k*DW +: DW] = '0;
        1:       t[k*DW +: DW] = DW'(MAXV);
        default: t[k*DW +: DW] = DW'($urandom % (MAXV + 1));
      endcase
    end
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [25*DW-1:0] w, input logic r, input logic c);
    in_valid   = v;
    in_win     = w;
    in_row_odd = r;
    in_col_odd = c;
    #1;
    if (v && in_ready) begin
      q.push_back(model(w, r, c));
      sent++;
    end
  endtask

  task automatic directed(input string tag, input logic [25*DW-1:0] w, input logic r,
                          input logic c, input int er, input int eg, input int eb);
    out_ready = 1'b1;
    send(1'b1, w, r, c);
    step();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_lat3"}, 32'(out_valid), 32'd1);
    chk({tag, "_r"}, 32'(out_r), 32'(er));
    chk({tag, "_g"}, 32'(out_g), 32'(eg));
    chk({tag, "_b"}, 32'(out_b), 32'(eb));
    step();
  endtask

  // Output monitor: ordering against the scoreboard and stability while stalled.
  always @(posedge clk) begin
    #3;
    if (!rst_n) begin
      have_prev = 0;
    end else begin
      if (have_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({out_r, out_g, out_b}), 32'(prev));
      end
      have_prev = out_valid && !out_ready;
      prev      = '{out_r, out_g, out_b};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          chk("out_rgb", 32'({out_r, out_g, out_b}), 32'(q.pop_front()));
          rcv++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25*DW-1:0] w;
    int base_s, base_r;

    rst_n = 1'b0; in_valid = 1'b0; in_win = '0; in_row_odd = 1'b0;
    in_col_odd = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'({out_r, out_g, out_b}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();

    w = '0;
    for (int k = 0; k < 25; k++) w[k*DW +: DW] = DW'(512);
    for (int p = 0; p < 4; p++)
      directed($sformatf("flat_p%0d", p), w, 1'(p >> 1), 1'(p), 512, 512, 512);

    // BAYER=3 (BGGR): parity (1,1) is an R site, (1,0) is G in an R row.
    directed("r_site_c", put('0, 3, 3, 1023), 1'b1, 1'b1, 1023, 512, 767);
    w = put(put(put(put('0, 1, 3, 1023), 5, 3, 1023), 3, 1, 1023), 3, 5, 1023);
    directed("r_site_ring2", w, 1'b1, 1'b1, 0, 0, 0);
    w = put(put(put('0, 3, 3, 1023), 3, 2, 1023), 3, 4, 1023);
    directed("gr_site", w, 1'b1, 1'b0, 1023, 1023, 639);
    directed("gb_site", w, 1'b0, 1'b1, 639, 1023, 1023);
    directed("b_site_c", put('0, 3, 3, 1023), 1'b0, 1'b0, 767, 512, 1023);

    base_s = sent;
    base_r = rcv;
    for (int k = 0; k < 40; k++) begin
      out_ready = !(k >= 4 && k <= 8);
      if (sent - base_s < 8) send(1'b1, rand_win(), 1'($urandom), 1'($urandom));
      else                   send(1'b0, rand_win(), 1'($urandom), 1'($urandom));
      if (k == 2) chk("stall_ready_pre", 32'(in_ready), 32'd1);
      if (k == 6) chk("stall_ready_full", 32'(in_ready), 32'd0);
      if (k == 9) chk("stall_ready_resume", 32'(in_ready), 32'd1);
      step();
    end
    chk("stall_sent", 32'(sent - base_s), 32'd8);
    chk("stall_rcv", 32'(rcv - base_r), 32'd8);

    for (int k = 0; k < 300; k++) begin
      out_ready = ($urandom % 4) != 0;
      send(1'(($urandom % 3) != 0), rand_win(), 1'($urandom), 1'($urandom));
      chk("rand_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (8) step();
    chk("rand_drain", 32'(q.size()), 32'd0);
    chk("rand_count", 32'(rcv), 32'(sent));

    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(1'b1, rand_win(), 1'($urandom), 1'($urandom));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_outs", 32'({out_r, out_g, out_b}), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    step();
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("arst_no_stale", 32'(out_valid), 32'd0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
